// File: rtl/sound_player.sv
// Buzzer sequencer: on a play strobe, plays a fixed note sequence for the selected sound code as a square wave.
// Optional SOUND_PWM_VOLUME_EN adds a 3-bit volume input that gates the output with a free-running PWM.
module sound_player #(
   parameter int CLK_FREQ_HZ = 25_000_000,
   parameter int NOTE_TICKS  = 2_500_000,
   parameter int GAP_TICKS   = 250_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       play,
   input  logic [1:0] sel,
   input  logic       mute,
`ifdef SOUND_PWM_VOLUME_EN
   input  logic [2:0] volume,
`endif
   output logic       audio_out,
   output logic       busy,
   output logic       done,
   output logic [1:0] state_dbg
);

   // play is a fire-and-forget strobe: it is accepted in any cycle it is high
   // (there is no ready), and busy/done report progress of the latest request.

   localparam int HP_C6 = CLK_FREQ_HZ / (2 * 1047);
   localparam int HP_C5 = CLK_FREQ_HZ / (2 * 523);
   localparam int HP_E5 = CLK_FREQ_HZ / (2 * 659);
   localparam int HP_G5 = CLK_FREQ_HZ / (2 * 784);
   localparam int HP_G3 = CLK_FREQ_HZ / (2 * 196);
   localparam int HP_C3 = CLK_FREQ_HZ / (2 * 131);

   // 131 Hz is the lowest note, so it has the longest half-period.
   localparam int HW      = (HP_C3 > 1) ? $clog2(HP_C3 + 1) : 1;
   localparam int DUR_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
   localparam int DW      = (DUR_MAX > 1) ? $clog2(DUR_MAX + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TONE = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [1:0]      sel_q, sel_n;
   logic [1:0]      idx, idx_n;
   logic [HW-1:0]   half_cnt, half_n;
   logic [DW-1:0]   dur_cnt, dur_n;
   logic            square, square_n;
   logic            done_q, done_n;
   logic            note_end;
   int              hp;

   function automatic int note_hp(input logic [1:0] s, input logic [1:0] i);
      case (s)
         2'd0: note_hp = HP_C6;
         2'd1: begin
            case (i)
               2'd0:    note_hp = HP_C5;
               2'd1:    note_hp = HP_E5;
               default: note_hp = HP_G5;
            endcase
         end
         2'd2: note_hp = (i == 2'd0) ? HP_G3 : HP_C3;
         default: begin
            case (i)
               2'd0:    note_hp = HP_C5;
               2'd1:    note_hp = HP_E5;
               2'd2:    note_hp = HP_G5;
               default: note_hp = HP_C6;
            endcase
         end
      endcase
   endfunction

   function automatic logic [1:0] last_idx(input logic [1:0] s);
      case (s)
         2'd0:    last_idx = 2'd0;
         2'd1:    last_idx = 2'd2;
         2'd2:    last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         sel_q    <= 2'd0;
         idx      <= 2'd0;
         half_cnt <= '0;
         dur_cnt  <= '0;
         square   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         sel_q    <= sel_n;
         idx      <= idx_n;
         half_cnt <= half_n;
         dur_cnt  <= dur_n;
         square   <= square_n;
         done_q   <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      sel_n    = sel_q;
      idx_n    = idx;
      half_n   = half_cnt;
      dur_n    = dur_cnt;
      square_n = square;
      done_n   = 1'b0;
      note_end = 1'b0;
      hp       = note_hp(sel_q, idx);

      case (state)
         IDLE: begin
            square_n = 1'b0;
         end
         TONE: begin
            dur_n = dur_cnt + 1'b1;
            if (int'(half_cnt) == hp - 1) begin
               half_n   = '0;
               square_n = ~square;
            end else begin
               half_n = half_cnt + 1'b1;
            end
            // Leaving the note: every following note or gap starts low.
            if (int'(dur_cnt) == NOTE_TICKS - 1) begin
               dur_n    = '0;
               half_n   = '0;
               square_n = 1'b0;
               if (GAP_TICKS == 0) note_end = 1'b1;
               else                state_n  = GAP;
            end
         end
         GAP: begin
            square_n = 1'b0;
            dur_n    = dur_cnt + 1'b1;
            if (int'(dur_cnt) == GAP_TICKS - 1) begin
               dur_n    = '0;
               note_end = 1'b1;
            end
         end
         default: begin
            state_n  = IDLE;
            square_n = 1'b0;
         end
      endcase

      if (note_end) begin
         if (idx == last_idx(sel_q)) begin
            state_n = IDLE;
            done_n  = 1'b1;
         end else begin
            idx_n   = idx + 1'b1;
            state_n = TONE;
         end
      end

      // A new request overrides everything, including a final-note expiry.
      if (play) begin
         state_n  = TONE;
         sel_n    = sel;
         idx_n    = 2'd0;
         half_n   = '0;
         dur_n    = '0;
         square_n = 1'b0;
         done_n   = 1'b0;
      end
   end

`ifdef SOUND_PWM_VOLUME_EN
   logic [2:0] pwm_cnt;

   always_ff @(posedge clk) begin
      if (reset) pwm_cnt <= 3'd0;
      else       pwm_cnt <= pwm_cnt + 3'd1;
   end

   assign audio_out = square & (pwm_cnt <= volume) & ~mute;
`else
   assign audio_out = square & ~mute;
`endif

   assign busy      = (state != IDLE);
   assign done      = done_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player: two instances (10-cycle gap and no gap) share inputs and are checked
// cycle by cycle against a division-based waveform model.
module tb_sound_player;

   localparam int CLK_HZ = 20_000;
   localparam int NT     = 100;
   localparam int GT     = 10;

   logic       clk = 1'b0;
   logic       reset, play, mute;
   logic [1:0] sel;
   logic       a_audio, a_busy, a_done;
   logic       b_audio, b_busy, b_done;
   logic [1:0] a_state, b_state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sound_player #(.CLK_FREQ_HZ(CLK_HZ), .NOTE_TICKS(NT), .GAP_TICKS(GT)) dut_a (
      .clk(clk), .reset(reset), .play(play), .sel(sel), .mute(mute),
`ifdef SOUND_PWM_VOLUME_EN
      .volume(3'd7),
`endif
      .audio_out(a_audio), .busy(a_busy), .done(a_done), .state_dbg(a_state)
   );

   sound_player #(.CLK_FREQ_HZ(CLK_HZ), .NOTE_TICKS(NT), .GAP_TICKS(0)) dut_b (
      .clk(clk), .reset(reset), .play(play), .sel(sel), .mute(mute),
`ifdef SOUND_PWM_VOLUME_EN
      .volume(3'd7),
`endif
      .audio_out(b_audio), .busy(b_busy), .done(b_done), .state_dbg(b_state)
   );

   typedef struct packed {
      logic [1:0]      sel;
      logic            mute;
      logic [2:0]      n;
      logic [3:0][7:0] hp;
   } rec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_play(input logic [1:0] s);
      sel  = s;
      play = 1'b1;
      tick();
      play = 1'b0;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic exp_audio(input rec_t r, input int gap, input int c);
      int nl, k, t;
      nl = NT + gap;
      k  = c / nl;
      t  = c % nl;
      if (k >= int'(r.n)) return 1'b0;
      if (t >= NT) return 1'b0;
      if (r.mute) return 1'b0;
      return ((t / int'(r.hp[k])) % 2) == 1;
   endfunction

   // Starts at the first cycle after play; checks audio, busy and done on both instances.
   task automatic check_window(input rec_t r, input string name);
      int   err_a[2], err_b[2], err_d[2], first[2];
      logic act_a, act_b, act_d, ex_a, ex_b, ex_d;
      int   gap, len, total;
      len = int'(r.n) * (NT + GT) + 15;
      for (int d = 0; d < 2; d++) begin
         err_a[d] = 0; err_b[d] = 0; err_d[d] = 0; first[d] = -1;
      end
      for (int c = 0; c < len; c++) begin
         for (int d = 0; d < 2; d++) begin
            gap   = (d == 0) ? GT : 0;
            total = int'(r.n) * (NT + gap);
            act_a = (d == 0) ? a_audio : b_audio;
            act_b = (d == 0) ? a_busy  : b_busy;
            act_d = (d == 0) ? a_done  : b_done;
            ex_a  = exp_audio(r, gap, c);
            ex_b  = (c < total);
            ex_d  = (c == total);
            if (act_a != ex_a) begin
               err_a[d]++;
               if (first[d] < 0) first[d] = c;
            end
            if (act_b != ex_b) err_b[d]++;
            if (act_d != ex_d) err_d[d]++;
         end
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         n_tests += 3;
         if (err_a[d] != 0) begin
            n_fail++;
            $display("FAIL %s dut%0d audio: %0d wrong cycles (first at offset %0d), expected 0",
                     name, d, err_a[d], first[d]);
         end
         if (err_b[d] != 0) begin
            n_fail++;
            $display("FAIL %s dut%0d busy: %0d wrong cycles, expected 0", name, d, err_b[d]);
         end
         if (err_d[d] != 0) begin
            n_fail++;
            $display("FAIL %s dut%0d done: %0d wrong cycles, expected 0", name, d, err_d[d]);
         end
      end
   endtask

   task automatic check_idle(input string name);
      chk({name, " a_audio"}, int'(a_audio), 0);
      chk({name, " a_busy"},  int'(a_busy),  0);
      chk({name, " a_done"},  int'(a_done),  0);
      chk({name, " b_audio"}, int'(b_audio), 0);
      chk({name, " b_busy"},  int'(b_busy),  0);
      chk({name, " b_done"},  int'(b_done),  0);
   endtask

   rec_t vec[6];
   rec_t ui_rec, nl_rec;
   int   cnt_a, cnt_b;

   initial begin
      // HP = 20000/(2f): 1047->9, 523->19, 659->15, 784->12, 196->51, 131->76
      vec[0] = '{sel: 2'd0, mute: 1'b0, n: 3'd1, hp: {8'd0,  8'd0,  8'd0,  8'd9}};
      vec[1] = '{sel: 2'd1, mute: 1'b0, n: 3'd3, hp: {8'd0,  8'd12, 8'd15, 8'd19}};
      vec[2] = '{sel: 2'd2, mute: 1'b0, n: 3'd2, hp: {8'd0,  8'd0,  8'd76, 8'd51}};
      vec[3] = '{sel: 2'd3, mute: 1'b0, n: 3'd4, hp: {8'd9,  8'd12, 8'd15, 8'd19}};
      vec[4] = '{sel: 2'd3, mute: 1'b1, n: 3'd4, hp: {8'd9,  8'd12, 8'd15, 8'd19}};
      vec[5] = '{sel: 2'd0, mute: 1'b1, n: 3'd1, hp: {8'd0,  8'd0,  8'd0,  8'd9}};
      ui_rec = vec[0];
      nl_rec = vec[1];

      reset = 1'b1; play = 1'b0; sel = 2'd0; mute = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      check_idle("reset");

      for (int i = 0; i < 6; i++) begin
         mute = vec[i].mute;
         pulse_play(vec[i].sel);
         check_window(vec[i], $sformatf("vec%0d", i));
         mute = 1'b0;
      end

      // Reset at cycle 150 of CELEBRATION.
      pulse_play(2'd3);
      repeat (149) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("mid_reset");
      cnt_a = 0; cnt_b = 0;
      for (int c = 0; c < 500; c++) begin
         if (a_done || a_busy) cnt_a++;
         if (b_done || b_busy) cnt_b++;
         tick();
      end
      chk("mid_reset a quiet", cnt_a, 0);
      chk("mid_reset b quiet", cnt_b, 0);

      // CRASH aborted at cycle 60 by UI_PRESS.
      pulse_play(2'd2);
      cnt_a = 0; cnt_b = 0;
      for (int c = 0; c < 59; c++) begin
         if (a_done) cnt_a++;
         if (b_done) cnt_b++;
         tick();
      end
      chk("abort a early done", cnt_a, 0);
      chk("abort b early done", cnt_b, 0);
      pulse_play(2'd0);
      check_window(ui_rec, "abort_restart");

      // Retrigger in the same cycle as the final-note expiry of the gapped instance.
      pulse_play(2'd0);
      cnt_a = 0;
      for (int c = 0; c < 109; c++) begin
         if (a_done) cnt_a++;
         tick();
      end
      chk("expiry a early done", cnt_a, 0);
      chk("expiry a busy at last cycle", int'(a_busy), 1);
      pulse_play(2'd1);
      check_window(nl_rec, "expiry_retrigger");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
